// File: rtl/rx_frame_pkg.sv
// Shared types, state encodings and helpers for the receive deframer.
package rx_frame_pkg;

   localparam int unsigned BYTE_W = 8;

   // Deframer FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t HUNT    = 2'd0;
   localparam state_t HEADER  = 2'd1;
   localparam state_t PAYLOAD = 2'd2;
   localparam state_t CRC     = 2'd3;

   // CRC-8 generator polynomial x^8 + x^2 + x + 1
   localparam logic [BYTE_W-1:0] CRC8_POLY = 8'h07;

   // Output byte beat as stored in the FIFO
   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } axis_byte_t;

   // Number of set bits in a 64-bit vector
   function automatic int unsigned popcount64(input logic [63:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

   // One serial CRC-8 step, data bit entering MSB first
   function automatic logic [BYTE_W-1:0] crc8_step(input logic [BYTE_W-1:0] crc,
                                                   input logic              b);
      logic [BYTE_W-1:0] nxt;
      nxt = {crc[BYTE_W-2:0], 1'b0};
      if (crc[BYTE_W-1] ^ b) begin
         nxt = nxt ^ CRC8_POLY;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/axis_byte_fifo.sv
// First-word-fall-through byte FIFO (data + last) with registered AXIS outputs.
// A push into a full FIFO succeeds if a pop happens in the same cycle; otherwise
// it is dropped and reported on drop_c.
module axis_byte_fifo
   import rx_frame_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  axis_byte_t        wdata,
   output logic              drop_c,
   output logic [BYTE_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   axis_byte_t    mem [DEPTH];
   axis_byte_t    head_q;
   axis_byte_t    head_d;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_d;
   logic [CW-1:0] count;
   logic [CW-1:0] count_d;
   logic          full;
   logic          pop_c;
   logic          push_ok_c;

   assign pop_c     = m_axis_tvalid & m_axis_tready;
   assign push_ok_c = push & (~full | pop_c);
   assign drop_c    = push & full & ~pop_c;

   assign m_axis_tdata = head_q.data;
   assign m_axis_tlast = head_q.last;

   // Next occupancy and next head entry; a write into the head slot bypasses memory
   always_comb begin
      rd_ptr_d = rd_ptr + AW'(pop_c);
      count_d  = count + CW'(push_ok_c) - CW'(pop_c);
      head_d   = '0;
      if (count_d != '0) begin
         if (push_ok_c && (wr_ptr == rd_ptr_d)) begin
            head_d = wdata;
         end else begin
            head_d = mem[rd_ptr_d];
         end
      end
   end

   // Pointers, occupancy and registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         full          <= 1'b0;
         m_axis_tvalid <= 1'b0;
         head_q        <= '0;
      end else begin
         if (push_ok_c) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr        <= rd_ptr_d;
         count         <= count_d;
         full          <= (count_d == CW'(DEPTH));
         m_axis_tvalid <= (count_d != '0);
         head_q        <= head_d;
      end
   end

   // Storage array, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/rx_frame_deframer.sv
// Bit-level receive deframer: Hamming-tolerant sync search with BPSK polarity
// resolution, length header parsing and payload byte packing onto AXI-Stream.
// Optional trailer check is enabled by defining DEFRAMER_CRC_EN.
module rx_frame_deframer
   import rx_frame_pkg::*;
#(
   parameter int unsigned SYNC_LEN   = 32,
   parameter logic [63:0] SYNC_WORD  = 64'hD391_7A5C,
   parameter int unsigned MAX_ERR    = 2,
   parameter int unsigned LEN_BITS   = 8,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              rx_bit,
   input  logic              new_bit,
   output logic [BYTE_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              msg_found,
   output logic              inv_msg_found,
   output logic              overflow,
   output logic              crc_err,
   output logic              busy
);

   localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];
   localparam int unsigned CNT_MAX = (LEN_BITS > BYTE_W) ? LEN_BITS : BYTE_W;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t              state;
   state_t              state_d;
   logic [SYNC_LEN-1:0] sync_sr;
   logic [SYNC_LEN-1:0] sync_d;
   logic                pol;
   logic                pol_d;
   logic [CNT_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]    bit_cnt_d;
   logic [LEN_BITS-1:0] byte_cnt;
   logic [LEN_BITS-1:0] byte_cnt_d;
   logic [BYTE_W-1:0]   byte_sr;
   logic [BYTE_W-1:0]   byte_sr_d;
   logic                msg_d;
   logic                inv_d;
   logic                ovf_d;
`ifdef DEFRAMER_CRC_EN
   logic [BYTE_W-1:0]   crc;
   logic [BYTE_W-1:0]   crc_d;
   logic                crc_err_d;
`endif

   logic                bit_acc_c;
   logic                bit_c;
   logic [SYNC_LEN-1:0] sync_shift_c;
   int unsigned         errs_c;
   logic                push_c;
   axis_byte_t          push_byte_c;
   logic                drop_c;

   assign bit_acc_c    = new_bit & en;
   assign bit_c        = rx_bit ^ pol;
   assign sync_shift_c = {sync_sr[SYNC_LEN-2:0], rx_bit};
   assign errs_c       = popcount64(64'(sync_shift_c ^ SYNC_PAT));

   // Next-state, datapath and pulse decode for every accepted bit
   always_comb begin
      state_d     = state;
      sync_d      = sync_sr;
      pol_d       = pol;
      bit_cnt_d   = bit_cnt;
      byte_cnt_d  = byte_cnt;
      byte_sr_d   = byte_sr;
      msg_d       = 1'b0;
      inv_d       = 1'b0;
      ovf_d       = 1'b0;
      push_c      = 1'b0;
      push_byte_c = '0;
`ifdef DEFRAMER_CRC_EN
      crc_d       = crc;
      crc_err_d   = 1'b0;
`endif
      if (bit_acc_c) begin
         case (state)
            HUNT: begin
               sync_d = sync_shift_c;
               if (errs_c <= MAX_ERR) begin
                  pol_d     = 1'b0;
                  msg_d     = 1'b1;
                  state_d   = HEADER;
                  bit_cnt_d = '0;
`ifdef DEFRAMER_CRC_EN
                  crc_d     = '0;
`endif
               end else if (errs_c >= SYNC_LEN - MAX_ERR) begin
                  pol_d     = 1'b1;
                  inv_d     = 1'b1;
                  state_d   = HEADER;
                  bit_cnt_d = '0;
`ifdef DEFRAMER_CRC_EN
                  crc_d     = '0;
`endif
               end
            end
            HEADER: begin
               byte_cnt_d = {byte_cnt[LEN_BITS-2:0], bit_c};
`ifdef DEFRAMER_CRC_EN
               crc_d      = crc8_step(crc, bit_c);
`endif
               if (bit_cnt == CNT_W'(LEN_BITS - 1)) begin
                  bit_cnt_d = '0;
                  if (byte_cnt_d == '0) begin
                     state_d = HUNT;
                     sync_d  = '0;
                  end else begin
                     state_d = PAYLOAD;
                  end
               end else begin
                  bit_cnt_d = bit_cnt + CNT_W'(1);
               end
            end
            PAYLOAD: begin
               byte_sr_d = {byte_sr[BYTE_W-2:0], bit_c};
`ifdef DEFRAMER_CRC_EN
               crc_d     = crc8_step(crc, bit_c);
`endif
               if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                  bit_cnt_d        = '0;
                  push_c           = 1'b1;
                  push_byte_c.last = (byte_cnt == LEN_BITS'(1));
                  push_byte_c.data = byte_sr_d;
                  byte_cnt_d       = byte_cnt - LEN_BITS'(1);
                  if (drop_c) begin
                     ovf_d   = 1'b1;
                     state_d = HUNT;
                     sync_d  = '0;
                  end else if (byte_cnt == LEN_BITS'(1)) begin
`ifdef DEFRAMER_CRC_EN
                     state_d = CRC;
`else
                     state_d = HUNT;
                     sync_d  = '0;
`endif
                  end
               end else begin
                  bit_cnt_d = bit_cnt + CNT_W'(1);
               end
            end
`ifdef DEFRAMER_CRC_EN
            CRC: begin
               byte_sr_d = {byte_sr[BYTE_W-2:0], bit_c};
               if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                  bit_cnt_d = '0;
                  crc_err_d = (byte_sr_d != crc);
                  state_d   = HUNT;
                  sync_d    = '0;
               end else begin
                  bit_cnt_d = bit_cnt + CNT_W'(1);
               end
            end
`endif
            default: begin
               state_d = HUNT;
               sync_d  = '0;
            end
         endcase
      end
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= HUNT;
         sync_sr       <= '0;
         pol           <= 1'b0;
         bit_cnt       <= '0;
         byte_cnt      <= '0;
         byte_sr       <= '0;
         msg_found     <= 1'b0;
         inv_msg_found <= 1'b0;
         overflow      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_d;
         sync_sr       <= sync_d;
         pol           <= pol_d;
         bit_cnt       <= bit_cnt_d;
         byte_cnt      <= byte_cnt_d;
         byte_sr       <= byte_sr_d;
         msg_found     <= msg_d;
         inv_msg_found <= inv_d;
         overflow      <= ovf_d;
         busy          <= (state_d != HUNT);
      end
   end

`ifdef DEFRAMER_CRC_EN
   // Running CRC over header and payload, and trailer mismatch pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc     <= '0;
         crc_err <= 1'b0;
      end else begin
         crc     <= crc_d;
         crc_err <= crc_err_d;
      end
   end
`else
   assign crc_err = 1'b0;
`endif

   // Output byte queue
   axis_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .push          (push_c),
      .wdata         (push_byte_c),
      .drop_c        (drop_c),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Self-checking bench for rx_frame_deframer (scoreboard of expected AXIS beats).
module tb_rx_frame_deframer;

   localparam logic [31:0] SYNC = 32'hD391_7A5C;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       rx_bit;
   logic       new_bit;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       m_axis_tlast;
   logic       msg_found;
   logic       inv_msg_found;
   logic       overflow;
   logic       crc_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int n_msg, n_inv, n_ovf, n_crc, n_beats;
   logic [8:0] exp_q[$];
   logic [7:0] pl[$];
   logic       prev_stall = 1'b0;
   logic [8:0] prev_out;
   logic       bb_done;
`ifdef DEFRAMER_CRC_EN
   logic [7:0] crc_xor;
`endif

   always #5 clk = ~clk;

   rx_frame_deframer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .rx_bit        (rx_bit),
      .new_bit       (new_bit),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .msg_found     (msg_found),
      .inv_msg_found (inv_msg_found),
      .overflow      (overflow),
      .crc_err       (crc_err),
      .busy          (busy)
   );

   // Output monitor: pulse counters, AXIS hold check and scoreboard compare
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (msg_found)     n_msg++;
         if (inv_msg_found) n_inv++;
         if (overflow)      n_ovf++;
         if (crc_err)       n_crc++;
         if (prev_stall) begin
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, prev_out}) begin
               errors++;
               $display("FAIL axis_hold: got valid=%0b last=%0b data=%02h, required valid=1 last=%0b data=%02h",
                        m_axis_tvalid, m_axis_tlast, m_axis_tdata, prev_out[8], prev_out[7:0]);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            logic [8:0] e;
            n_beats++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected: got last=%0b data=%02h, required no beat",
                        m_axis_tlast, m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== e) begin
                  errors++;
                  $display("FAIL beat: got last=%0b data=%02h, required last=%0b data=%02h",
                           m_axis_tlast, m_axis_tdata, e[8], e[7:0]);
               end
            end
         end
         prev_stall = m_axis_tvalid & ~m_axis_tready;
         prev_out   = {m_axis_tlast, m_axis_tdata};
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
      logic [7:0] c;
      logic       fb;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0};
         if (fb) c = c ^ 8'h07;
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx_bit  = b;
      new_bit = 1'b1;
      tick();
      new_bit = 1'b0;
      tick();
   endtask

   task automatic send_byte(input logic inv, input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i] ^ inv);
   endtask

   task automatic send_sync(input logic inv, input logic [31:0] flip);
      for (int i = 31; i >= 0; i--) send_bit(SYNC[i] ^ flip[i] ^ inv);
   endtask

   // Header + first nsend bytes of pl; first npush bytes are expected on the output
   task automatic send_body(input logic inv, input logic [7:0] len, input int nsend, input int npush);
`ifdef DEFRAMER_CRC_EN
      logic [7:0] c;
      c = crc8_byte(8'h00, len);
`endif
      send_byte(inv, len);
      for (int i = 0; i < nsend; i++) begin
         if (i < npush) exp_q.push_back({1'(i == int'(len) - 1), pl[i]});
`ifdef DEFRAMER_CRC_EN
         c = crc8_byte(c, pl[i]);
`endif
         send_byte(inv, pl[i]);
      end
`ifdef DEFRAMER_CRC_EN
      if (nsend == int'(len)) send_byte(inv, c ^ crc_xor);
`endif
   endtask

   task automatic clear_counts();
      n_msg = 0; n_inv = 0; n_ovf = 0; n_crc = 0; n_beats = 0;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      new_bit = 1'b0;
      en      = 1'b1;
      tick();
      tick();
      exp_q.delete();
      rst_n = 1'b1;
      tick();
      clear_counts();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || m_axis_tvalid); i++) tick();
      checks++;
      if (exp_q.size() != 0 || m_axis_tvalid) begin
         errors++;
         $display("FAIL %s drain_timeout: got %0d beats pending valid=%0b, required 0 pending valid=0",
                  name, exp_q.size(), m_axis_tvalid);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; rx_bit = 1'b0; new_bit = 1'b0; m_axis_tready = 1'b0;
      tick();
      checks++;
      if ({m_axis_tdata, m_axis_tvalid, m_axis_tlast, msg_found, inv_msg_found, overflow, crc_err, busy} !== 15'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %04h, required 0000",
                  {m_axis_tdata, m_axis_tvalid, m_axis_tlast, msg_found, inv_msg_found, overflow, crc_err, busy});
      end
      apply_reset();
      check_int("reset_busy_after_release", int'(busy), 0);
   endtask

   task automatic test_clean();
      apply_reset();
      m_axis_tready = 1'b1;
      pl = '{8'h68, 8'h65, 8'h6C};
      send_sync(1'b0, 32'h0);
      check_int("clean_msg_found", n_msg, 1);
      check_int("clean_busy", int'(busy), 1);
      send_body(1'b0, 8'd3, 3, 3);
      wait_drain("clean");
      check_int("clean_beats", n_beats, 3);
      check_int("clean_inv_none", n_inv, 0);
      check_int("clean_busy_end", int'(busy), 0);
   endtask

   task automatic test_inverted();
      apply_reset();
      m_axis_tready = 1'b1;
      pl = '{8'h68, 8'h65, 8'h6C};
      send_sync(1'b1, 32'h0);
      check_int("inv_pulse", n_inv, 1);
      check_int("inv_no_true_pulse", n_msg, 0);
      send_body(1'b1, 8'd3, 3, 3);
      wait_drain("inverted");
      check_int("inv_beats", n_beats, 3);
   endtask

   task automatic test_sync_errors();
      apply_reset();
      m_axis_tready = 1'b1;
      pl = '{8'h68, 8'h65, 8'h6C};
      send_sync(1'b0, 32'h0002_0001);
      check_int("err2_msg_found", n_msg, 1);
      send_body(1'b0, 8'd3, 3, 3);
      wait_drain("err2");
      check_int("err2_beats", n_beats, 3);
      apply_reset();
      send_sync(1'b0, 32'h0010_0201);
      check_int("err3_no_pulse", n_msg + n_inv, 0);
      check_int("err3_busy", int'(busy), 0);
      check_int("err3_no_output", int'(m_axis_tvalid), 0);
   endtask

   task automatic test_overflow();
      apply_reset();
      m_axis_tready = 1'b0;
      pl.delete();
      for (int i = 0; i < 12; i++) pl.push_back(8'(i * 17 + 3));
      send_sync(1'b0, 32'h0);
      send_body(1'b0, 8'd12, 9, 8);
      check_int("ovf_pulse", n_ovf, 1);
      check_int("ovf_busy", int'(busy), 0);
      checks++;
      if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, pl[0]}) begin
         errors++;
         $display("FAIL ovf_head: got valid=%0b data=%02h, required valid=1 data=%02h",
                  m_axis_tvalid, m_axis_tdata, pl[0]);
      end
      m_axis_tready = 1'b1;
      wait_drain("overflow");
      check_int("ovf_beats", n_beats, 8);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      m_axis_tready = 1'b1;
      pl = '{8'h68, 8'h65, 8'h6C};
      send_sync(1'b0, 32'h0);
      send_body(1'b0, 8'd3, 1, 1);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, msg_found, busy} !== 12'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got valid=%0b last=%0b data=%02h msg=%0b busy=%0b, required all 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, msg_found, busy);
      end
      apply_reset();
      m_axis_tready = 1'b1;
      send_sync(1'b0, 32'h0);
      send_body(1'b0, 8'd3, 3, 3);
      wait_drain("midreset");
      check_int("midreset_beats", n_beats, 3);
      check_int("midreset_msg", n_msg, 1);
   endtask

   task automatic test_en_gating();
      apply_reset();
      m_axis_tready = 1'b1;
      pl = '{8'hA5, 8'h3C};
      send_sync(1'b0, 32'h0);
      en = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(1'(i & 1));
      en = 1'b1;
      send_body(1'b0, 8'd2, 2, 2);
      wait_drain("en_gating");
      check_int("en_gating_beats", n_beats, 2);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      bb_done = 1'b0;
      fork
         begin
            pl = '{8'h11, 8'h22, 8'h33, 8'h44};
            send_sync(1'b0, 32'h0);
            send_body(1'b0, 8'd4, 4, 4);
            pl = '{8'hFE, 8'h01};
            send_sync(1'b1, 32'h0);
            send_body(1'b1, 8'd2, 2, 2);
            bb_done = 1'b1;
         end
         begin
            while (!bb_done) begin
               m_axis_tready = 1'($urandom_range(0, 1));
               tick();
            end
         end
      join
      m_axis_tready = 1'b1;
      wait_drain("back_to_back");
      check_int("b2b_beats", n_beats, 6);
      check_int("b2b_pulses", n_msg * 10 + n_inv, 11);
      check_int("b2b_no_ovf", n_ovf, 0);
   endtask

`ifdef DEFRAMER_CRC_EN
   task automatic test_crc();
      apply_reset();
      m_axis_tready = 1'b1;
      pl = '{8'h68};
      crc_xor = 8'h00;
      send_sync(1'b0, 32'h0);
      send_body(1'b0, 8'd1, 1, 1);
      tick();
      check_int("crc_good_no_err", n_crc, 0);
      crc_xor = 8'h01;
      send_sync(1'b0, 32'h0);
      send_body(1'b0, 8'd1, 1, 1);
      tick();
      check_int("crc_bad_pulse", n_crc, 1);
      crc_xor = 8'h00;
      wait_drain("crc");
      check_int("crc_beats", n_beats, 2);
   endtask
`endif

   initial begin
`ifdef DEFRAMER_CRC_EN
      crc_xor = 8'h00;
`endif
      clear_counts();
      test_reset();
      test_clean();
      test_inverted();
      test_sync_errors();
      test_overflow();
      test_reset_mid();
      test_en_gating();
      test_back_to_back();
`ifdef DEFRAMER_CRC_EN
      test_crc();
`else
      check_int("crc_err_tied", n_crc, 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
